cache_miss_sequencer: RTL

//  Multi-cycle miss handler for the two-way data cache: sequences dirty-victim writeback, then line refill, over a req/ack RAM port.

---
 rtl/cache_miss_sequencer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/cache_miss_sequencer.sv
// Miss handler for the two-way data cache: dirty-victim writeback, then line refill, over a
// req/ack RAM port, with saturating miss and writeback statistics.
module cache_miss_sequencer #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned RAM_ADDR_WIDTH = 32,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      miss_req,
    input  logic                      wb_needed,
    input  logic [RAM_ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0]     wb_data,
    input  logic [RAM_ADDR_WIDTH-1:0] fill_addr,
    output logic                      stall,
    output logic                      ram_req,
    output logic                      ram_we,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0]     ram_wdata,
    input  logic                      ram_ack,
    input  logic [DATA_WIDTH-1:0]     ram_rdata,
    output logic                      fill_valid,
    output logic [DATA_WIDTH-1:0]     fill_data,
    output logic [CNT_WIDTH-1:0]      miss_count,
    output logic [CNT_WIDTH-1:0]      wb_count
);

    typedef enum logic [1:0] {
        StIdle      = 2'd0,
        StWriteback = 2'd1,
        StRefill    = 2'd2,
        StInstall   = 2'd3
    } state_e;

    localparam logic [CNT_WIDTH-1:0] CntMax = '1;

    state_e                    state_q, state_d;
    logic [RAM_ADDR_WIDTH-1:0] wb_addr_q, wb_addr_d;
    logic [RAM_ADDR_WIDTH-1:0] fill_addr_q, fill_addr_d;
    logic [DATA_WIDTH-1:0]     wb_data_q, wb_data_d;
    logic [DATA_WIDTH-1:0]     fill_data_q, fill_data_d;
    logic [CNT_WIDTH-1:0]      miss_count_q, miss_count_d;
    logic [CNT_WIDTH-1:0]      wb_count_q, wb_count_d;

    always_comb begin
        state_d      = state_q;
        wb_addr_d    = wb_addr_q;
        wb_data_d    = wb_data_q;
        fill_addr_d  = fill_addr_q;
        fill_data_d  = fill_data_q;
        miss_count_d = miss_count_q;
        wb_count_d   = wb_count_q;
        case (state_q)
            StIdle: begin
                if (miss_req) begin
                    // Word-align both addresses so ram_addr[1:0] is always zero.
                    wb_addr_d    = {wb_addr[RAM_ADDR_WIDTH-1:2], 2'b00};
                    wb_data_d    = wb_data;
                    fill_addr_d  = {fill_addr[RAM_ADDR_WIDTH-1:2], 2'b00};
                    miss_count_d = (miss_count_q == CntMax) ? miss_count_q
                                                            : miss_count_q + 1'b1;
                    state_d      = wb_needed ? StWriteback : StRefill;
                end
            end
            StWriteback: begin
                if (ram_ack) begin
                    wb_count_d = (wb_count_q == CntMax) ? wb_count_q : wb_count_q + 1'b1;
                    state_d    = StRefill;
                end
            end
            StRefill: begin
                if (ram_ack) begin
                    fill_data_d = ram_rdata;
                    state_d     = StInstall;
                end
            end
            StInstall: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            wb_addr_q    <= '0;
            wb_data_q    <= '0;
            fill_addr_q  <= '0;
            fill_data_q  <= '0;
            miss_count_q <= '0;
            wb_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            wb_addr_q    <= wb_addr_d;
            wb_data_q    <= wb_data_d;
            fill_addr_q  <= fill_addr_d;
            fill_data_q  <= fill_data_d;
            miss_count_q <= miss_count_d;
            wb_count_q   <= wb_count_d;
        end
    end

    // Only stall has a combinational input term, so the pipeline freezes in the miss cycle.
    always_comb begin
        stall      = (state_q == StIdle) ? miss_req : 1'b1;
        ram_req    = (state_q == StWriteback) || (state_q == StRefill);
        ram_we     = (state_q == StWriteback);
        ram_addr   = '0;
        ram_wdata  = '0;
        if (state_q == StWriteback) begin
            ram_addr  = wb_addr_q;
            ram_wdata = wb_data_q;
        end else if (state_q == StRefill) begin
            ram_addr  = fill_addr_q;
        end
        fill_valid = (state_q == StInstall);
        fill_data  = fill_data_q;
        miss_count = miss_count_q;
        wb_count   = wb_count_q;
    end

endmodule
